// File: rtl/stream_cmd_controller.sv
// Host command sequencer between the sync-245 RX FIFO and the camera capture path; configures the camera and gates frame-aligned streaming.
// host_read follows host_has_data by one cycle, commands act two cycles after host_read; the host is only served in IDLE, STREAM and ERROR.
module stream_cmd_controller #(
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned CFG_TIMEOUT = 2000000,
  parameter logic [7:0]  CMD_START   = 8'hAA,
  parameter logic [7:0]  CMD_SNAP    = 8'hA5,
  parameter logic [7:0]  CMD_STOP    = 8'h55,
  parameter logic [7:0]  CMD_RESET   = 8'h5A
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic [7:0]  host_data,
  input  logic        host_has_data,
  output logic        host_read,
  input  logic        sccb_done,
  input  logic        frame_done,
  input  logic        tx_full,
  output logic        link_rst,
  output logic        cam_start,
  output logic        stream_en,
  output logic [15:0] frame_count,
  output logic [15:0] drop_count,
  output logic [3:0]  state,
  output logic        cmd_error,
  output logic        cfg_timeout
);

  localparam int unsigned    RCW      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [23:0]    CFG_LAST = 24'(CFG_TIMEOUT - 1);

  typedef enum logic [3:0] {
    ST_STREAM = 4'd1,
    ST_READ   = 4'd2,
    ST_DECODE = 4'd3,
    ST_RESET  = 4'd4,
    ST_CONFIG = 4'd5,
    ST_ARM    = 4'd6,
    ST_DRAIN  = 4'd7,
    ST_IDLE   = 4'd12,
    ST_ERROR  = 4'd15
  } state_t;

  state_t         state_q, state_d;
  state_t         ret_q, ret_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [23:0]    cfg_timer_q, cfg_timer_d;
  logic           cfg_done_q, cfg_done_d;
  logic           mode_q, mode_d;          // 1 = single frame
  logic           link_rst_q;
  logic           cam_start_q, cam_start_d;
  logic           stream_en_q, stream_en_d;
  logic           cmd_error_q, cmd_error_d;
  logic           cfg_timeout_q, cfg_timeout_d;
  logic           clr_cnt;
  logic           ovf_q;
  logic [15:0]    frame_count_q, drop_count_q;
  logic           count_frame;
  logic           is_run_cmd;

  assign is_run_cmd  = (host_data == CMD_START) || (host_data == CMD_SNAP);
  assign count_frame = frame_done && stream_en_q;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    rst_cnt_d     = rst_cnt_q;
    cfg_timer_d   = cfg_timer_q;
    cfg_done_d    = cfg_done_q;
    mode_d        = mode_q;
    cam_start_d   = cam_start_q;
    stream_en_d   = stream_en_q;
    cmd_error_d   = cmd_error_q;
    cfg_timeout_d = cfg_timeout_q;
    clr_cnt       = 1'b0;

    case (state_q)
      ST_RESET: begin
        cam_start_d = 1'b0;
        stream_en_d = 1'b0;
        if (rst_cnt_q == RST_LAST) begin
          rst_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        if (host_has_data) begin
          state_d = ST_READ;
          ret_d   = ST_IDLE;
        end
      end

      ST_READ: state_d = ST_DECODE;

      ST_DECODE: begin
        if (host_data == CMD_RESET) begin
          state_d       = ST_RESET;
          rst_cnt_d     = '0;
          cfg_timer_d   = '0;
          cfg_done_d    = 1'b0;
          mode_d        = 1'b0;
          cam_start_d   = 1'b0;
          stream_en_d   = 1'b0;
          cmd_error_d   = 1'b0;
          cfg_timeout_d = 1'b0;
          clr_cnt       = 1'b1;
        end else if (ret_q == ST_ERROR) begin
          // only a reset gets out of ERROR
          cmd_error_d = 1'b1;
          state_d     = ST_ERROR;
        end else if (is_run_cmd) begin
          cmd_error_d = 1'b0;
          mode_d      = (host_data == CMD_SNAP);
          if (!cfg_done_q) begin
            state_d     = ST_CONFIG;
            cfg_timer_d = '0;
            cam_start_d = 1'b1;
          end else if (ret_q == ST_STREAM) begin
            state_d = ST_STREAM;
          end else begin
            state_d = ST_ARM;
          end
        end else if (host_data == CMD_STOP) begin
          cmd_error_d = 1'b0;
          state_d     = (ret_q == ST_STREAM) ? ST_DRAIN : ret_q;
        end else begin
          cmd_error_d = 1'b1;
          state_d     = ret_q;
        end
      end

      ST_CONFIG: begin
        cam_start_d = 1'b1;
        if (sccb_done) begin
          cfg_done_d  = 1'b1;
          cfg_timer_d = '0;
          state_d     = ST_ARM;
        end else if (cfg_timer_q == CFG_LAST) begin
          cfg_timer_d   = '0;
          cam_start_d   = 1'b0;
          stream_en_d   = 1'b0;
          cfg_timeout_d = 1'b1;
          state_d       = ST_ERROR;
        end else begin
          cfg_timer_d = cfg_timer_q + 24'd1;
        end
      end

      ST_ARM: begin
        // the frame in flight when arming is partial; start on the next one
        if (frame_done) begin
          stream_en_d = 1'b1;
          state_d     = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (frame_done && mode_q) begin
          stream_en_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (host_has_data) begin
          state_d = ST_READ;
          ret_d   = ST_STREAM;
        end
      end

      ST_DRAIN: begin
        if (frame_done) begin
          stream_en_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      ST_ERROR: begin
        cam_start_d   = 1'b0;
        stream_en_d   = 1'b0;
        cfg_timeout_d = 1'b1;
        if (host_has_data) begin
          state_d = ST_READ;
          ret_d   = ST_ERROR;
        end
      end

      default: begin
        state_d   = ST_RESET;
        rst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RESET;
      ret_q         <= ST_IDLE;
      rst_cnt_q     <= '0;
      cfg_timer_q   <= '0;
      cfg_done_q    <= 1'b0;
      mode_q        <= 1'b0;
      link_rst_q    <= 1'b1;
      cam_start_q   <= 1'b0;
      stream_en_q   <= 1'b0;
      cmd_error_q   <= 1'b0;
      cfg_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ret_q         <= ret_d;
      rst_cnt_q     <= rst_cnt_d;
      cfg_timer_q   <= cfg_timer_d;
      cfg_done_q    <= cfg_done_d;
      mode_q        <= mode_d;
      link_rst_q    <= (state_d == ST_RESET);
      cam_start_q   <= cam_start_d;
      stream_en_q   <= stream_en_d;
      cmd_error_q   <= cmd_error_d;
      cfg_timeout_q <= cfg_timeout_d;
    end
  end

  // Frames are counted on stream_en alone, so READ/DECODE/DRAIN still count.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
      ovf_q         <= 1'b0;
    end else if (clr_cnt) begin
      frame_count_q <= '0;
      drop_count_q  <= '0;
      ovf_q         <= 1'b0;
    end else if (count_frame) begin
      if (frame_count_q != 16'hFFFF) frame_count_q <= frame_count_q + 16'd1;
      if ((ovf_q || tx_full) && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      ovf_q <= 1'b0;
    end else if (tx_full && stream_en_q) begin
      ovf_q <= 1'b1;
    end
  end

  assign host_read   = (state_q == ST_READ);
  assign link_rst    = link_rst_q;
  assign cam_start   = cam_start_q;
  assign stream_en   = stream_en_q;
  assign frame_count = frame_count_q;
  assign drop_count  = drop_count_q;
  assign state       = state_q;
  assign cmd_error   = cmd_error_q;
  assign cfg_timeout = cfg_timeout_q;

endmodule

// File: tb/tb_stream_cmd_controller.sv
// Directed bench: dut runs with the default config timeout, dut2 with a short one for the timeout path.
module tb_stream_cmd_controller;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [7:0]  host_data = 8'h00;
  logic        host_has_data = 1'b0;
  logic        sccb_done = 1'b0;
  logic        frame_done = 1'b0;
  logic        tx_full = 1'b0;
  logic        host_read, link_rst, cam_start, stream_en, cmd_error, cfg_timeout;
  logic [15:0] frame_count, drop_count;
  logic [3:0]  state;

  logic [7:0]  host_data2 = 8'h00;
  logic        host_has_data2 = 1'b0;
  logic        host_read2, link_rst2, cam_start2, stream_en2, cmd_error2, cfg_timeout2;
  logic [15:0] frame_count2, drop_count2;
  logic [3:0]  state2;

  stream_cmd_controller dut (
    .sys_clk(sys_clk), .reset_n(reset_n), .host_data(host_data), .host_has_data(host_has_data),
    .host_read(host_read), .sccb_done(sccb_done), .frame_done(frame_done), .tx_full(tx_full),
    .link_rst(link_rst), .cam_start(cam_start), .stream_en(stream_en), .frame_count(frame_count),
    .drop_count(drop_count), .state(state), .cmd_error(cmd_error), .cfg_timeout(cfg_timeout)
  );

  stream_cmd_controller #(.CFG_TIMEOUT(50)) dut2 (
    .sys_clk(sys_clk), .reset_n(reset_n), .host_data(host_data2), .host_has_data(host_has_data2),
    .host_read(host_read2), .sccb_done(1'b0), .frame_done(1'b0), .tx_full(1'b0),
    .link_rst(link_rst2), .cam_start(cam_start2), .stream_en(stream_en2), .frame_count(frame_count2),
    .drop_count(drop_count2), .state(state2), .cmd_error(cmd_error2), .cfg_timeout(cfg_timeout2)
  );

  int checks = 0;
  int failures = 0;
  int rd1 = 0;
  int rd2 = 0;
  int exp_fc = 0;

  always @(posedge sys_clk) begin
    if (host_read === 1'b1) rd1++;
    if (host_read2 === 1'b1) rd2++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte; returns at the negedge where the command has taken effect.
  task automatic push(input bit second, input logic [7:0] b, input bit fd_in_decode);
    bit seen;
    seen = 1'b0;
    if (second) begin host_data2 = b; host_has_data2 = 1'b1; end
    else begin host_data = b; host_has_data = 1'b1; end
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge sys_clk);
      if ((second ? host_read2 : host_read) === 1'b1) seen = 1'b1;
    end
    host_has_data = 1'b0;
    host_has_data2 = 1'b0;
    chk("host_read_seen", 32'(seen), 32'd1);
    @(negedge sys_clk);
    chk("decode_state", 32'(second ? state2 : state), 32'd3);
    if (fd_in_decode) frame_done = 1'b1;
    @(negedge sys_clk);
    frame_done = 1'b0;
  endtask

  task automatic frame_pulse();
    frame_done = 1'b1;
    @(negedge sys_clk);
    frame_done = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  typedef struct {
    logic [7:0] cmd;
    int         nfr;
    logic [3:0] mid;
    logic       mid_se;
    logic [3:0] fin;
    logic       fin_se;
    logic       err;
    int         dfc;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int lr_cnt;
    int r0;
    int cnt;

    tbl[0] = '{8'h55, 2, 4'd7,  1'b1, 4'd12, 1'b0, 1'b0, 1};
    tbl[1] = '{8'hA5, 3, 4'd6,  1'b0, 4'd12, 1'b0, 1'b0, 1};
    tbl[2] = '{8'h13, 0, 4'd12, 1'b0, 4'd12, 1'b0, 1'b1, 0};
    tbl[3] = '{8'hAA, 2, 4'd6,  1'b0, 4'd1,  1'b1, 1'b0, 1};
    tbl[4] = '{8'hA5, 0, 4'd1,  1'b1, 4'd1,  1'b1, 1'b0, 0};
    tbl[5] = '{8'h77, 0, 4'd1,  1'b1, 4'd1,  1'b1, 1'b1, 0};
    tbl[6] = '{8'hAA, 1, 4'd1,  1'b1, 4'd1,  1'b1, 1'b0, 1};
    tbl[7] = '{8'hA5, 1, 4'd1,  1'b1, 4'd12, 1'b0, 1'b0, 1};
    tbl[8] = '{8'h55, 0, 4'd12, 1'b0, 4'd12, 1'b0, 1'b0, 0};

    // reset values
    repeat (3) @(negedge sys_clk);
    chk("rst_state", 32'(state), 32'd4);
    chk("rst_link_rst", 32'(link_rst), 32'd1);
    chk("rst_cam_start", 32'(cam_start), 32'd0);
    chk("rst_stream_en", 32'(stream_en), 32'd0);
    chk("rst_host_read", 32'(host_read), 32'd0);
    chk("rst_counts", 32'({frame_count, drop_count}), 32'd0);
    chk("rst_flags", 32'({cmd_error, cfg_timeout}), 32'd0);

    reset_n = 1'b1;
    lr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (link_rst === 1'b1) lr_cnt++;
      @(negedge sys_clk);
    end
    chk("link_rst_cycles", 32'(lr_cnt), 32'd4);
    chk("idle_after_reset", 32'(state), 32'd12);
    chk("idle_after_reset2", 32'(state2), 32'd12);

    // start, configure, arm, stream
    push(1'b0, 8'hAA, 1'b0);
    chk("start_config_state", 32'(state), 32'd5);
    chk("start_cam_start", 32'(cam_start), 32'd1);
    repeat (100) @(negedge sys_clk);
    chk("config_waits", 32'(state), 32'd5);
    sccb_done = 1'b1;
    @(negedge sys_clk);
    chk("arm_state", 32'(state), 32'd6);
    chk("arm_stream_en", 32'(stream_en), 32'd0);
    frame_done = 1'b1;
    @(negedge sys_clk);
    frame_done = 1'b0;
    chk("stream_en_after_first", 32'(stream_en), 32'd1);
    chk("stream_state", 32'(state), 32'd1);
    repeat (4) @(negedge sys_clk);
    frame_pulse();
    frame_pulse();
    exp_fc = 2;
    chk("frame_count_start", 32'(frame_count), 32'(exp_fc));
    chk("cam_start_held", 32'(cam_start), 32'd1);

    for (int i = 0; i < 9; i++) begin
      r0 = rd1;
      push(1'b0, tbl[i].cmd, 1'b0);
      chk($sformatf("v%0d_mid_state", i), 32'(state), 32'(tbl[i].mid));
      chk($sformatf("v%0d_mid_stream_en", i), 32'(stream_en), 32'(tbl[i].mid_se));
      chk($sformatf("v%0d_read_pulses", i), 32'(rd1 - r0), 32'd1);
      for (int f = 0; f < tbl[i].nfr; f++) frame_pulse();
      exp_fc += tbl[i].dfc;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].fin));
      chk($sformatf("v%0d_stream_en", i), 32'(stream_en), 32'(tbl[i].fin_se));
      chk($sformatf("v%0d_cmd_error", i), 32'(cmd_error), 32'(tbl[i].err));
      chk($sformatf("v%0d_frame_count", i), 32'(frame_count), 32'(exp_fc));
    end

    // overflow mid-frame, STOP decoded in the same cycle as frame_done
    push(1'b0, 8'hAA, 1'b0);
    chk("drop_arm", 32'(state), 32'd6);
    frame_pulse();
    chk("drop_stream", 32'(state), 32'd1);
    tx_full = 1'b1;
    @(negedge sys_clk);
    tx_full = 1'b0;
    repeat (2) @(negedge sys_clk);
    chk("drop_before_frame", 32'(drop_count), 32'd0);
    push(1'b0, 8'h55, 1'b1);
    exp_fc += 1;
    chk("stop_coincident_state", 32'(state), 32'd7);
    chk("stop_coincident_fc", 32'(frame_count), 32'(exp_fc));
    chk("stop_coincident_drop", 32'(drop_count), 32'd1);
    chk("drain_stream_en", 32'(stream_en), 32'd1);
    frame_pulse();
    exp_fc += 1;
    chk("drain_done_state", 32'(state), 32'd12);
    chk("drain_done_fc", 32'(frame_count), 32'(exp_fc));
    chk("drain_done_drop", 32'(drop_count), 32'd1);
    chk("drain_done_stream_en", 32'(stream_en), 32'd0);

    // saturation: a frame_done every cycle with the TX FIFO full
    push(1'b0, 8'hAA, 1'b0);
    frame_pulse();
    frame_done = 1'b1;
    tx_full = 1'b1;
    repeat (65540) @(negedge sys_clk);
    chk("sat_frame_count", 32'(frame_count), 32'hFFFF);
    chk("sat_drop_count", 32'(drop_count), 32'hFFFF);
    repeat (3) @(negedge sys_clk);
    chk("sat_hold_frame", 32'(frame_count), 32'hFFFF);
    chk("sat_hold_drop", 32'(drop_count), 32'hFFFF);
    frame_done = 1'b0;
    tx_full = 1'b0;
    @(negedge sys_clk);
    push(1'b0, 8'h5A, 1'b0);
    chk("cmd_reset_state", 32'(state), 32'd4);
    chk("cmd_reset_link_rst", 32'(link_rst), 32'd1);
    chk("cmd_reset_counts", 32'({frame_count, drop_count}), 32'd0);
    chk("cmd_reset_outputs", 32'({cam_start, stream_en}), 32'd0);
    repeat (5) @(negedge sys_clk);
    chk("cmd_reset_idle", 32'(state), 32'd12);
    chk("cmd_reset_link_low", 32'(link_rst), 32'd0);

    // configuration timeout on the short-timeout instance
    push(1'b1, 8'hAA, 1'b0);
    chk("to_config", 32'(state2), 32'd5);
    chk("to_cam_start", 32'(cam_start2), 32'd1);
    cnt = 0;
    while (state2 == 4'd5 && cnt < 200) begin
      cnt++;
      @(negedge sys_clk);
    end
    chk("to_config_cycles", 32'(cnt), 32'd50);
    chk("to_error_state", 32'(state2), 32'd15);
    chk("to_cfg_timeout", 32'(cfg_timeout2), 32'd1);
    chk("to_cam_start_off", 32'(cam_start2), 32'd0);
    push(1'b1, 8'hAA, 1'b0);
    chk("err_keeps_error", 32'(state2), 32'd15);
    chk("err_cmd_error", 32'(cmd_error2), 32'd1);
    chk("err_cfg_timeout", 32'(cfg_timeout2), 32'd1);
    push(1'b1, 8'h5A, 1'b0);
    chk("err_reset_state", 32'(state2), 32'd4);
    chk("err_reset_flags", 32'({cmd_error2, cfg_timeout2}), 32'd0);
    repeat (5) @(negedge sys_clk);
    chk("err_reset_idle", 32'(state2), 32'd12);
    chk("err_reset_link", 32'(link_rst2), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
